top_memoryaccess: RTL and testbench

Memory-access stage of the RockWave multi-cycle core. It sits directly downstream of the execute stage and consumes the `*_em` registers that stage produces. For load and store operations it runs a req/ack transaction on the data-memory port, extracting and extending load data or building byte-enabled store data. It registers the results into the `*_mw` registers for the writeback stage, and holds the state machine with `stall_memoryaccess` until the bus transaction completes.

---
 rtl/top_memoryaccess.sv | 224 ++++++++++++++++++++++
 tb/tb_top_memoryaccess.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_memoryaccess.sv
// -----------------------------------------------------------------------------
// top_memoryaccess
//
// Memory-access stage of the RockWave multi-cycle core. Consumes the *_em
// registers from execute; for loads and stores it runs one req/ack transaction
// on the data-memory port (lane-shifted store data with byte enables on the way
// out, lane extraction plus sign/zero extension on the way back) and registers
// the results into the *_mw registers for writeback. While a bus transaction is
// outstanding, stall_memoryaccess holds the core's phase.
//
// Ports
//   clk, rst_n            clock; reset (asynchronous, active-high despite the name)
//   phase_memoryaccess    memory-access phase, held high while stalled
//   decoded_op_em         decoded opcode (funct3 field, load bit, store bit)
//   alu_out_em            ALU result / effective address
//   rs2data_em            store data
//   rdsel_em              destination register
//   next_pc_em            next PC
//   jump_state_em         branch/jump taken
//   dmem_req/we/addr/wdata/be   data-memory request (stable from issue until ack)
//   dmem_rdata, dmem_ack  data-memory response
//   stall_memoryaccess    combinational hold for the phase state machine
//   *_mw                  registered results for writeback
//   access_err_mw         misaligned or unsupported-width access
// -----------------------------------------------------------------------------
module top_memoryaccess #(
    parameter int XLEN         = 32,
    parameter int OPLEN        = 10,
    parameter int FUNCT3_BIT_L = 0,
    parameter int FUNCT3_BIT_M = 2,
    parameter int LOAD_BIT     = 7,
    parameter int STORE_BIT    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             phase_memoryaccess,
    input  logic [OPLEN-1:0] decoded_op_em,
    input  logic [XLEN-1:0]  alu_out_em,
    input  logic [XLEN-1:0]  rs2data_em,
    input  logic [4:0]       rdsel_em,
    input  logic [XLEN-1:0]  next_pc_em,
    input  logic             jump_state_em,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_ack,
    output logic             stall_memoryaccess,
    output logic [XLEN-1:0]  rd_data_mw,
    output logic [4:0]       rdsel_mw,
    output logic [XLEN-1:0]  next_pc_mw,
    output logic             jump_state_mw,
    output logic [OPLEN-1:0] decoded_op_mw,
    output logic             access_err_mw
);

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    state_t state;

    // ---------------------------------------------------------------- decode
    logic [2:0] funct3;
    logic [1:0] lane;
    logic       is_load;
    logic       is_store;
    logic       mem_op;

    assign funct3   = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
    assign lane     = alu_out_em[1:0];
    assign is_load  = decoded_op_em[LOAD_BIT];
    // Both bits set is treated as a load, so the store bit only counts alone.
    assign is_store = decoded_op_em[STORE_BIT] & ~is_load;
    assign mem_op   = is_load | is_store;

    logic funct3_ok;
    logic aligned;
    logic legal;

    // NOTE: every variable assigned in an always_comb gets a default first,
    //       so no path through the case can leave it unassigned (no latch).
    always_comb begin
        funct3_ok = 1'b0;
        aligned   = 1'b0;
        case (funct3)
            3'b000:         begin funct3_ok = 1'b1;    aligned = 1'b1;            end
            3'b001:         begin funct3_ok = 1'b1;    aligned = ~lane[0];        end
            3'b010:         begin funct3_ok = 1'b1;    aligned = (lane == 2'b00); end
            3'b100:         begin funct3_ok = is_load; aligned = 1'b1;            end
            3'b101:         begin funct3_ok = is_load; aligned = ~lane[0];        end
            default:        begin funct3_ok = 1'b0;    aligned = 1'b0;            end
        endcase
    end

    assign legal = funct3_ok & aligned;

    // Lane-shifted store data and byte enables, captured when the request issues.
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = rs2data_em;
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << lane;
                wdata_next = {4{rs2data_em[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << lane;
                wdata_next = {2{rs2data_em[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = rs2data_em;
            end
        endcase
    end

    // ------------------------------------------------------ load extraction
    // Width and lane are captured at issue so the extraction does not depend
    // on the execute registers staying put during the wait.
    logic [2:0]      funct3_q;
    logic [1:0]      lane_q;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    assign shifted = dmem_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------ handshake/stall
    logic start;
    logic commit;

    assign start              = (state == ST_IDLE) & phase_memoryaccess & mem_op & legal;
    assign stall_memoryaccess = start | ((state == ST_REQ) & ~dmem_ack);
    assign commit             = phase_memoryaccess & ~stall_memoryaccess;
    assign dmem_req           = (state == ST_REQ);

    // NOTE: reset is asynchronous and active-high; every register, including
    //       the bus outputs, clears at once so a pending request drops without
    //       waiting for ack.
    // NOTE: sequential state uses non-blocking assignments only, so every
    //       register samples values from before the edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= ST_IDLE;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            funct3_q      <= '0;
            lane_q        <= '0;
            rd_data_mw    <= '0;
            rdsel_mw      <= '0;
            next_pc_mw    <= '0;
            jump_state_mw <= 1'b0;
            decoded_op_mw <= '0;
            access_err_mw <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_REQ;
                        dmem_we    <= is_store;
                        dmem_addr  <= {alu_out_em[XLEN-1:2], 2'b00};
                        dmem_wdata <= wdata_next;
                        dmem_be    <= be_next;
                        funct3_q   <= funct3;
                        lane_q     <= lane;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (commit) begin
                next_pc_mw    <= next_pc_em;
                jump_state_mw <= jump_state_em;
                decoded_op_mw <= decoded_op_em;
                if (state == ST_REQ) begin
                    // Bus transaction completing this cycle.
                    access_err_mw <= 1'b0;
                    if (dmem_we) begin
                        rd_data_mw <= '0;
                        rdsel_mw   <= '0;
                    end else begin
                        rd_data_mw <= load_data;
                        rdsel_mw   <= rdsel_em;
                    end
                end else if (mem_op) begin
                    // A legal memory op stalls in IDLE, so only an illegal one
                    // can commit from here.
                    access_err_mw <= 1'b1;
                    rd_data_mw    <= '0;
                    rdsel_mw      <= '0;
                end else begin
                    access_err_mw <= 1'b0;
                    rd_data_mw    <= alu_out_em;
                    rdsel_mw      <= rdsel_em;
                end
            end
        end
    end

endmodule

// File: tb/tb_top_memoryaccess.sv
// -----------------------------------------------------------------------------
// tb_top_memoryaccess
//
// Self-checking bench for top_memoryaccess. A driver issues directed and
// random operations; a behavioural model derives the expected writeback values,
// bus request and stall length and pushes them into queues. A bus responder
// checks each request against its queue and acks after the chosen number of
// wait cycles; a monitor compares every commit (and every hold cycle) against
// the writeback queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_top_memoryaccess;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        phase_memoryaccess = 1'b0;
    logic [9:0]  decoded_op_em = '0;
    logic [31:0] alu_out_em = '0;
    logic [31:0] rs2data_em = '0;
    logic [4:0]  rdsel_em = '0;
    logic [31:0] next_pc_em = '0;
    logic        jump_state_em = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        stall_memoryaccess;
    logic [31:0] rd_data_mw;
    logic [4:0]  rdsel_mw;
    logic [31:0] next_pc_mw;
    logic        jump_state_mw;
    logic [9:0]  decoded_op_mw;
    logic        access_err_mw;

    always #5 clk = ~clk;

    top_memoryaccess dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .phase_memoryaccess (phase_memoryaccess),
        .decoded_op_em      (decoded_op_em),
        .alu_out_em         (alu_out_em),
        .rs2data_em         (rs2data_em),
        .rdsel_em           (rdsel_em),
        .next_pc_em         (next_pc_em),
        .jump_state_em      (jump_state_em),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_rdata         (dmem_rdata),
        .dmem_ack           (dmem_ack),
        .stall_memoryaccess (stall_memoryaccess),
        .rd_data_mw         (rd_data_mw),
        .rdsel_mw           (rdsel_mw),
        .next_pc_mw         (next_pc_mw),
        .jump_state_mw      (jump_state_mw),
        .decoded_op_mw      (decoded_op_mw),
        .access_err_mw      (access_err_mw)
    );

    typedef struct {
        logic [31:0] rd_data;
        logic [4:0]  rdsel;
        logic [31:0] next_pc;
        logic        jump;
        logic [9:0]  op;
        logic        err;
        int          stalls;
    } commit_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          waits;
    } bus_t;

    commit_t sb_q[$];
    bus_t    bus_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------ driver
    // Model the operation from the access rules, queue the expectations, then
    // present it and wait until the stage stops stalling.
    task automatic issue(input logic [9:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rdsel, input logic [31:0] npc, input logic jump,
                         input logic [31:0] rdata, input int waits, input bit expect_commit);
        commit_t     c;
        bus_t        b;
        bit          ld, st;
        int          f3, size, lane;
        logic [31:0] v, mask;
        bit          done;

        ld   = op[7];
        st   = op[8] && !op[7];
        f3   = int'(op[2:0]);
        lane = int'(alu[1:0]);
        size = 0;
        if (ld) begin
            case (f3)
                0, 4:    size = 1;
                1, 5:    size = 2;
                2:       size = 4;
                default: size = 0;
            endcase
        end else if (st) begin
            case (f3)
                0:       size = 1;
                1:       size = 2;
                2:       size = 4;
                default: size = 0;
            endcase
        end

        c.next_pc = npc;
        c.jump    = jump;
        c.op      = op;
        c.err     = 1'b0;
        c.stalls  = 0;
        if (!(ld || st)) begin
            c.rd_data = alu;
            c.rdsel   = rdsel;
        end else if (size == 0 || (lane % size) != 0) begin
            c.err     = 1'b1;
            c.rd_data = '0;
            c.rdsel   = '0;
        end else begin
            c.stalls = waits + 1;
            b.we     = st;
            b.addr   = {alu[31:2], 2'b00};
            b.rdata  = rdata;
            b.waits  = waits;
            b.be     = '0;
            b.wdata  = '0;
            if (st) begin
                for (int i = 0; i < size; i++) b.be[lane + i] = 1'b1;
                for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
                c.rd_data = '0;
                c.rdsel   = '0;
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
                v    = (rdata >> (8*lane)) & mask;
                if (f3 < 4 && size < 4 && v[8*size-1]) v = v | ~mask;
                c.rd_data = v;
                c.rdsel   = rdsel;
            end
            bus_q.push_back(b);
        end
        if (expect_commit) sb_q.push_back(c);

        decoded_op_em      = op;
        alu_out_em         = alu;
        rs2data_em         = rs2;
        rdsel_em           = rdsel;
        next_pc_em         = npc;
        jump_state_em      = jump;
        phase_memoryaccess = 1'b1;
        if (!expect_commit) return;

        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!stall_memoryaccess) done = 1'b1;
        end
        if (!done) fail_event("commit_timeout");
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------ bus responder
    bus_t cur;
    bit   in_txn = 1'b0;
    int   wcnt   = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                in_txn   = 1'b0;
                dmem_ack = 1'b0;
            end else if (dmem_req) begin
                if (!in_txn) begin
                    if (bus_q.size() == 0) begin
                        fail_event("unexpected_dmem_req");
                    end else begin
                        cur    = bus_q.pop_front();
                        in_txn = 1'b1;
                        wcnt   = cur.waits;
                    end
                end
                if (in_txn) begin
                    check("dmem_addr", dmem_addr, cur.addr);
                    check("dmem_we", 32'(dmem_we), 32'(cur.we));
                    if (cur.we) begin
                        check("dmem_be", 32'(dmem_be), 32'(cur.be));
                        check("dmem_wdata", dmem_wdata, cur.wdata);
                    end
                    if (wcnt == 0) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = cur.rdata;
                        in_txn     = 1'b0;
                    end else begin
                        wcnt--;
                        dmem_ack   = 1'b0;
                        dmem_rdata = $urandom;
                    end
                end else begin
                    dmem_ack = 1'b1;
                end
            end else begin
                // Stray acks outside a request must be ignored by the stage.
                dmem_ack   = ($urandom_range(3) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // ------------------------------------------------------------ monitor
    commit_t last;
    commit_t exp_c;
    bit      pend;
    int      stall_cnt = 0;

    initial begin
        last = '{default: 0};
        forever begin
            @(negedge clk);
            pend = phase_memoryaccess && !stall_memoryaccess && !rst_n;
            if (phase_memoryaccess && stall_memoryaccess && !rst_n) stall_cnt++;
            @(posedge clk);
            #1;
            if (rst_n) begin
                last      = '{default: 0};
                stall_cnt = 0;
            end else if (pend) begin
                if (sb_q.size() == 0) begin
                    fail_event("unexpected_commit");
                end else begin
                    exp_c = sb_q.pop_front();
                    check("rd_data_mw", rd_data_mw, exp_c.rd_data);
                    check("rdsel_mw", 32'(rdsel_mw), 32'(exp_c.rdsel));
                    check("next_pc_mw", next_pc_mw, exp_c.next_pc);
                    check("jump_state_mw", 32'(jump_state_mw), 32'(exp_c.jump));
                    check("decoded_op_mw", 32'(decoded_op_mw), 32'(exp_c.op));
                    check("access_err_mw", 32'(access_err_mw), 32'(exp_c.err));
                    check("stall_cycles", 32'(stall_cnt), 32'(exp_c.stalls));
                    last = exp_c;
                end
                stall_cnt = 0;
            end else begin
                check("hold_rd_data_mw", rd_data_mw, last.rd_data);
                check("hold_access_err_mw", 32'(access_err_mw), 32'(last.err));
            end
        end
    end

    // ----------------------------------------------------------- watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ sequence
    task automatic check_all_zero(input string tag);
        check({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_dmem_addr"}, dmem_addr, 32'd0);
        check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_dmem_be"}, 32'(dmem_be), 32'd0);
        check({tag, "_stall"}, 32'(stall_memoryaccess), 32'd0);
        check({tag, "_rd_data_mw"}, rd_data_mw, 32'd0);
        check({tag, "_rdsel_mw"}, 32'(rdsel_mw), 32'd0);
        check({tag, "_next_pc_mw"}, next_pc_mw, 32'd0);
        check({tag, "_jump_state_mw"}, 32'(jump_state_mw), 32'd0);
        check({tag, "_decoded_op_mw"}, 32'(decoded_op_mw), 32'd0);
        check({tag, "_access_err_mw"}, 32'(access_err_mw), 32'd0);
    endtask

    initial begin
        logic [9:0]  op;
        logic [31:0] alu;
        int          gap;
        bit          seen;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b0;

        // Directed cases.
        issue(10'h000, 32'h1234_5678, 32'h0BAD_0BAD, 5'd3, 32'hA0A0_A0A0, 1'b1, 32'h0, 0, 1'b1);
        issue(10'h080, 32'h0000_1003, 32'h0, 5'd7, 32'h0000_0104, 1'b0, 32'h80FF_0000, 0, 1'b1);
        issue(10'h084, 32'h0000_1003, 32'h0, 5'd8, 32'h0000_0108, 1'b0, 32'h80FF_0000, 0, 1'b1);
        issue(10'h101, 32'h0000_2002, 32'hDEAD_BEEF, 5'd9, 32'h0000_010C, 1'b0, 32'h0, 3, 1'b1);
        issue(10'h082, 32'h0000_0002, 32'h0, 5'd10, 32'h0000_0110, 1'b1, 32'h0, 0, 1'b1);
        issue(10'h082, 32'h0000_3000, 32'h0, 5'd11, 32'h0000_0114, 1'b0, 32'hCAFE_F00D, 2, 1'b1);
        issue(10'h181, 32'h0000_3002, 32'h0, 5'd12, 32'h0000_0118, 1'b0, 32'h8001_7FFF, 1, 1'b1);
        issue(10'h104, 32'h0000_3000, 32'h1111_2222, 5'd13, 32'h0000_011C, 1'b0, 32'h0, 0, 1'b1);
        issue(10'h087, 32'h0000_3000, 32'h0, 5'd14, 32'h0000_0120, 1'b0, 32'h0, 0, 1'b1);
        issue(10'h100, 32'h0000_4001, 32'h0000_00A5, 5'd15, 32'h0000_0124, 1'b1, 32'h0, 0, 1'b1);

        // Random traffic with idle gaps during which garbage must not commit.
        for (int n = 0; n < 300; n++) begin
            op      = 10'($urandom);
            op[8:7] = 2'($urandom_range(3));
            alu     = $urandom;
            issue(op, alu, $urandom, 5'($urandom), $urandom, 1'($urandom),
                  $urandom, $urandom_range(4), 1'b1);
            gap = $urandom_range(2);
            if (gap > 0) begin
                phase_memoryaccess = 1'b0;
                decoded_op_em      = 10'($urandom);
                alu_out_em         = $urandom;
                rdsel_em           = 5'($urandom);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        // Reset in the middle of a request.
        issue(10'h082, 32'h0000_4000, 32'h0, 5'd5, 32'h0000_0200, 1'b1, 32'h1234_ABCD, 6, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #3;
            if (dmem_req) seen = 1'b1;
        end
        if (!seen) fail_event("reset_test_no_req");
        rst_n              = 1'b1;
        phase_memoryaccess = 1'b0;
        #1;
        check_all_zero("midreq_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Fresh load after reset release.
        issue(10'h082, 32'h0000_5004, 32'h0, 5'd21, 32'h0000_0300, 1'b0, 32'h5A5A_0F0F, 1, 1'b1);
        issue(10'h085, 32'h0000_5006, 32'h0, 5'd22, 32'h0000_0304, 1'b1, 32'hF00D_8000, 0, 1'b1);
        phase_memoryaccess = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("sb_queue_drained", 32'(sb_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
